vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
REQ-002 SHALL have ports (name, direction, width, meaning):
- CLOCK_50, in, 1, sole clock, 50 MHz
- reset, in, 1, synchronous, active-high
- pix_r / pix_g / pix_b, in, 8 each, colour returned by the upstream pixel source
- pix_req, out, 1, pixel request strobe
- pix_x, out, 10, column of the requested pixel
- pix_y, out, 10, row of the requested pixel
- frame_start, out, 1, one-cycle pulse at the start of each frame
- VGA_CLK, out, 1, pixel clock to the DAC
- VGA_HS, out, 1, horizontal sync
- VGA_VS, out, 1, vertical sync
- VGA_BLANK_N, out, 1, active-video flag
- VGA_SYNC_N, out, 1, composite sync
- VGA_R / VGA_G / VGA_B, out, 8 each, colour to the DAC
REQ-003 SHALL use CLOCK_50 as its only clock; reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL generate an internal pixel enable, pe, that is high on every second CLOCK_50 cycle (25 MHz); pe SHALL be 0 on the first cycle after reset release.
REQ-005 VGA_CLK SHALL be a register that toggles every CLOCK_50 cycle; it SHALL rise on the cycle pe is high.
REQ-006 hcnt (10 bit) SHALL increment on pe and wrap from H_TOTAL-1 to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
REQ-007 vcnt (10 bit) SHALL increment on pe only when hcnt wraps, and SHALL wrap from V_TOTAL-1 to 0, where V_TOTAL = 525.
REQ-008 On the simultaneous wrap of hcnt and vcnt, both counters SHALL become 0 on the same cycle.
REQ-009 Active video SHALL be defined as hcnt < H_ACTIVE and vcnt < V_ACTIVE.
REQ-010 Raw hsync SHALL be low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751); it SHALL be high otherwise.
REQ-011 Raw vsync SHALL be low for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491); it SHALL be high otherwise.
REQ-012 pix_req SHALL be high for exactly the one CLOCK_50 cycle in which pe is high and the counters are in active video; pix_x/pix_y SHALL equal hcnt/vcnt during that cycle.
REQ-013 pix_x and pix_y SHALL hold their values between requests.
REQ-014 Upstream SHALL present pix_r/g/b valid on the next pe cycle after pix_req, a fixed 2-cycle latency; the block SHALL sample them on that pe.
REQ-015 VGA_HS, VGA_VS and VGA_BLANK_N SHALL be delayed through a 2-stage pe-enabled pipeline so they align with the registered colour.
REQ-016 VGA_R/G/B SHALL be forced to 0 whenever the delayed blank indicates blanking; the upstream colour SHALL be ignored then.
REQ-017 VGA_SYNC_N SHALL be held constant at 0.
REQ-018 frame_start SHALL pulse for one CLOCK_50 cycle on the pe where hcnt=0 and vcnt=0.
REQ-019 Pipeline registers SHALL update only on pe; all outputs SHALL be stable across the non-pe cycle.

Reset
REQ-020 While reset is high:
- hcnt, vcnt and pe SHALL be 0
- VGA_CLK SHALL be 0
- pix_req and frame_start SHALL be 0
- pix_x and pix_y SHALL be 0
- VGA_HS and VGA_VS SHALL be 1
- VGA_BLANK_N SHALL be 0
- VGA_R/G/B SHALL be 0
REQ-021 Reset asserted mid-frame SHALL take effect on the next CLOCK_50 edge with no partial-line completion.
REQ-022 After reset release, the first pe SHALL present hcnt=0, vcnt=0; frame_start SHALL pulse on that pe.

Verification
REQ-023 Line timing: free-run from reset -> 800 pe per line; VGA_HS low for exactly 96 pe starting 656 pe (plus 2 pipeline pe) after line start.
REQ-024 Frame timing: free-run one frame -> 525 lines; VGA_VS low for exactly 2 lines (vcnt 490..491); frame_start period = 840000 CLOCK_50 cycles.
REQ-025 Alignment: upstream returns pix_r = pix_x[7:0] -> each VGA_BLANK_N-high pe shows VGA_R equal to the column; the first visible pixel of a line shows 0 and the last shows 0x7F (639 mod 256).
REQ-026 Blanking: upstream drives constant 0xFF on all colours -> VGA_R/G/B = 0 whenever VGA_BLANK_N=0; exactly 640x480 = 307200 non-zero pixels per frame.
REQ-027 Reset mid-frame: assert reset at vcnt=200, hcnt=300 for 3 cycles -> all outputs at their REQ-020 values; frame_start pulses on the first pe after release; pix_x/pix_y = 0/0 on the first pix_req.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing, pixel-request interface and aligned colour output from a 50 MHz clock
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic       pix_req,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       pe;
    logic       hWrap;
    logic       vWrap;
    logic       active;
    logic       hsRaw;
    logic       vsRaw;
    logic [9:0] hCnt;
    logic [9:0] vCnt;
    logic [1:0] hsPipe;
    logic [1:0] vsPipe;
    logic [1:0] blankPipe;

    assign VGA_SYNC_N  = 1'b0;
    assign VGA_HS      = hsPipe[1];
    assign VGA_VS      = vsPipe[1];
    assign VGA_BLANK_N = blankPipe[1];

    // raster decode of the current counter position
    always_comb begin
        hWrap  = hCnt == H_LAST;
        vWrap  = vCnt == V_LAST;
        active = (hCnt < H_VIS) && (vCnt < V_VIS);
        hsRaw  = !((hCnt >= HS_BEG) && (hCnt < HS_END));
        vsRaw  = !((vCnt >= VS_BEG) && (vCnt < VS_END));
    end

    // half-rate pixel enable; VGA_CLK is high exactly in the pe cycle
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pe      <= 1'b0;
            VGA_CLK <= 1'b0;
        end else begin
            pe      <= ~pe;
            VGA_CLK <= ~VGA_CLK;
        end
    end

    // horizontal and vertical position counters advance once per pixel
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (pe) begin
            hCnt <= hWrap ? '0 : hCnt + 10'd1;
            if (hWrap)
                vCnt <= vWrap ? '0 : vCnt + 10'd1;
        end
    end

    // request strobes are prepared in the idle cycle so they land registered on the pe cycle
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            pix_req     <= ~pe & active;
            frame_start <= ~pe & (hCnt == '0) & (vCnt == '0);
            if (~pe & active) begin
                pix_x <= hCnt;
                pix_y <= vCnt;
            end
        end
    end

    // two-pixel sync/blank delay matching the upstream colour latency; colour gated by blank
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hsPipe    <= 2'b11;
            vsPipe    <= 2'b11;
            blankPipe <= 2'b00;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else if (pe) begin
            hsPipe    <= {hsPipe[0], hsRaw};
            vsPipe    <= {vsPipe[0], vsRaw};
            blankPipe <= {blankPipe[0], active};
            VGA_R     <= blankPipe[0] ? pix_r : 8'd0;
            VGA_G     <= blankPipe[0] ? pix_g : 8'd0;
            VGA_B     <= blankPipe[0] ? pix_b : 8'd0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: compares a full-size and a shrunken timing generator against an arithmetic raster model
module tb_vga_timing_gen;
    typedef struct packed {
        logic       req, fs, clk, hs, vs, blankN, syncN;
        logic [7:0] r, g, b;
        logic [9:0] x, y;
    } sig_t;

    int hAct[2] = '{640, 20};
    int hFp[2]  = '{16, 3};
    int hSw[2]  = '{96, 5};
    int hBp[2]  = '{48, 4};
    int vAct[2] = '{480, 10};
    int vFp[2]  = '{10, 2};
    int vSw[2]  = '{2, 2};
    int vBp[2]  = '{33, 3};

    logic       CLOCK_50;
    logic       reset;
    logic       reqS[2], fsS[2], clkS[2], hsS[2], vsS[2], blankS[2], syncS[2];
    logic [7:0] rS[2], gS[2], bS[2], pixR[2], pixG[2], pixB[2];
    logic [9:0] xS[2], yS[2];

    int         errors = 0;
    int         checks = 0;
    int         t = 0;
    bit         started = 0;
    bit         mode = 0;
    logic [7:0] key = 8'd0;

    vga_timing_gen u0 (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .pix_r(pixR[0]), .pix_g(pixG[0]), .pix_b(pixB[0]),
        .pix_req(reqS[0]), .pix_x(xS[0]), .pix_y(yS[0]), .frame_start(fsS[0]),
        .VGA_CLK(clkS[0]), .VGA_HS(hsS[0]), .VGA_VS(vsS[0]), .VGA_BLANK_N(blankS[0]),
        .VGA_SYNC_N(syncS[0]), .VGA_R(rS[0]), .VGA_G(gS[0]), .VGA_B(bS[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u1 (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .pix_r(pixR[1]), .pix_g(pixG[1]), .pix_b(pixB[1]),
        .pix_req(reqS[1]), .pix_x(xS[1]), .pix_y(yS[1]), .frame_start(fsS[1]),
        .VGA_CLK(clkS[1]), .VGA_HS(hsS[1]), .VGA_VS(vsS[1]), .VGA_BLANK_N(blankS[1]),
        .VGA_SYNC_N(syncS[1]), .VGA_R(rS[1]), .VGA_G(gS[1]), .VGA_B(bS[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic logic [23:0] colourOf(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] s;
        s = x + y;
        return mode ? 24'hFFFFFF : {x[7:0] ^ key, y[7:0], s[7:0]};
    endfunction

    // t counts cycles since the last edge that saw reset; pixel position = t/2, outputs lag two pixels
    task automatic model(input int i, input int tc, output sig_t e);
        int ht, vt, pos, h, v, pd, hd, vd;
        ht = hAct[i] + hFp[i] + hSw[i] + hBp[i];
        vt = vAct[i] + vFp[i] + vSw[i] + vBp[i];
        pos = tc / 2;
        h = pos % ht;
        v = (pos / ht) % vt;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.clk = (tc % 2) == 1;
        e.req = e.clk && h < hAct[i] && v < vAct[i];
        e.fs = e.clk && h == 0 && v == 0;
        e.x = 10'(h);
        e.y = 10'(v);
        pd = pos - 2;
        if (pd >= 0) begin
            hd = pd % ht;
            vd = (pd / ht) % vt;
            e.hs = !(hd >= hAct[i] + hFp[i] && hd < hAct[i] + hFp[i] + hSw[i]);
            e.vs = !(vd >= vAct[i] + vFp[i] && vd < vAct[i] + vFp[i] + vSw[i]);
            e.blankN = hd < hAct[i] && vd < vAct[i];
            if (e.blankN)
                {e.r, e.g, e.b} = colourOf(10'(hd), 10'(vd));
        end
    endtask

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        forever begin
            @(posedge CLOCK_50);
            started = 1'b1;
            t = reset ? 0 : t + 1;
        end
    end

    // per-cycle comparison plus the upstream source with its fixed two-cycle return latency
    initial begin
        sig_t       e, o;
        string      p;
        logic [9:0] expX[2], expY[2], x1[2], y1[2], x2[2], y2[2];
        logic       req1[2], req2[2];
        for (int i = 0; i < 2; i++) begin
            {pixR[i], pixG[i], pixB[i]} = 24'd0;
            req1[i] = 1'b0;
            req2[i] = 1'b0;
        end
        forever begin
            @(negedge CLOCK_50);
            if (started) begin
                for (int i = 0; i < 2; i++) begin
                    model(i, t, e);
                    if (t == 0) begin
                        expX[i] = '0;
                        expY[i] = '0;
                    end else if (e.req) begin
                        expX[i] = e.x;
                        expY[i] = e.y;
                    end
                    e.x = expX[i];
                    e.y = expY[i];
                    o = {reqS[i], fsS[i], clkS[i], hsS[i], vsS[i], blankS[i], syncS[i],
                         rS[i], gS[i], bS[i], xS[i], yS[i]};
                    p = $sformatf("u%0d t=%0d ", i, t);
                    check({p, "pix_req"}, o.req, e.req);
                    check({p, "frame_start"}, o.fs, e.fs);
                    check({p, "VGA_CLK"}, o.clk, e.clk);
                    check({p, "VGA_HS"}, o.hs, e.hs);
                    check({p, "VGA_VS"}, o.vs, e.vs);
                    check({p, "VGA_BLANK_N"}, o.blankN, e.blankN);
                    check({p, "VGA_SYNC_N"}, o.syncN, e.syncN);
                    check({p, "VGA_R"}, o.r, e.r);
                    check({p, "VGA_G"}, o.g, e.g);
                    check({p, "VGA_B"}, o.b, e.b);
                    check({p, "pix_x"}, o.x, e.x);
                    check({p, "pix_y"}, o.y, e.y);
                    {pixR[i], pixG[i], pixB[i]} = req2[i] ? colourOf(x2[i], y2[i])
                                                : (mode ? 24'hFFFFFF : 24'($urandom));
                    req2[i] = req1[i];
                    x2[i] = x1[i];
                    y2[i] = y1[i];
                    req1[i] = o.req;
                    x1[i] = o.x;
                    y1[i] = o.y;
                end
            end
        end
    end

    initial begin
        int lit0, lit1, hsLow0;
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (4000) @(negedge CLOCK_50);
        repeat (3) begin
            repeat ($urandom_range(200, 2500)) @(negedge CLOCK_50);
            reset = 1'b1;
            @(posedge CLOCK_50);
            key = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
            reset = 1'b0;
        end
        repeat ($urandom_range(300, 900)) @(negedge CLOCK_50);
        reset = 1'b1;
        @(posedge CLOCK_50);
        mode = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        lit0 = 0;
        lit1 = 0;
        hsLow0 = 0;
        for (int k = 0; k < 1600; k++) begin
            @(negedge CLOCK_50);
            if (clkS[0] && rS[0] != 8'd0) lit0++;
            if (clkS[0] && !hsS[0]) hsLow0++;
            if (k < 1088 && clkS[1] && rS[1] != 8'd0) lit1++;
        end
        check("u0 lit pixels per line", lit0, 640);
        check("u0 hsync low pixels per line", hsLow0, 96);
        check("u1 lit pixels per frame", lit1, 200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
